// File: rtl/hazard_if.sv
// D-stage decoder inputs and hazard/forwarding outputs of the pipeline
// hazard controller, bundled so the datapath and the controller share one port.
interface hazard_if #(
   parameter int AW = 5,
   parameter int TW = 2
);
   logic [AW-1:0] rs_d;
   logic [AW-1:0] rt_d;
   logic [TW-1:0] tuse_rs_d;
   logic [TW-1:0] tuse_rt_d;
   logic [AW-1:0] a3_d;
   logic          regwrite_d;
   logic [TW-1:0] tnew_d;
   logic          md_start_d;
   logic          md_div_d;
   logic          md_use_d;

   logic          stall;
   logic [2:0]    fwd_rs_d;
   logic [2:0]    fwd_rt_d;
   logic [2:0]    fwd_rs_e;
   logic [2:0]    fwd_rt_e;
   logic [2:0]    fwd_rt_m;
   logic          md_busy;

   // Decoder / datapath side: drives the D-stage description, consumes controls.
   modport master (
      output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, regwrite_d, tnew_d,
             md_start_d, md_div_d, md_use_d,
      input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
   );

   // Hazard controller side.
   modport slave (
      input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, regwrite_d, tnew_d,
             md_start_d, md_div_d, md_use_d,
      output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline. Keeps a
// registered shadow of the E/M/W writers (aging Tnew each cycle), derives all
// forward selects and the D-stage stall from it, and tracks mult/div occupancy.
module hazard_ctrl #(
   parameter int AW      = 5,
   parameter int TW      = 2,
   parameter int MUL_CYC = 5,
   parameter int DIV_CYC = 10,
   parameter int CW      = 4
) (
   input logic     clk,
   input logic     rst_n,
   hazard_if.slave hz
);

   // Shadow of the E stage
   logic          e_valid_q, e_valid_d;
   logic          e_regwrite_q, e_regwrite_d;
   logic [AW-1:0] e_a3_q, e_a3_d;
   logic [TW-1:0] e_tnew_q, e_tnew_d;
   logic [AW-1:0] e_rs_q, e_rs_d;
   logic [AW-1:0] e_rt_q, e_rt_d;
   logic          e_md_start_q, e_md_start_d;
   logic          e_md_div_q, e_md_div_d;
   // Shadow of the M stage
   logic          m_valid_q, m_valid_d;
   logic          m_regwrite_q, m_regwrite_d;
   logic [AW-1:0] m_a3_q, m_a3_d;
   logic [TW-1:0] m_tnew_q, m_tnew_d;
   logic [AW-1:0] m_rt_q, m_rt_d;
   // Shadow of the W stage
   logic          w_valid_q, w_valid_d;
   logic          w_regwrite_q, w_regwrite_d;
   logic [AW-1:0] w_a3_q, w_a3_d;
   logic [TW-1:0] w_tnew_q, w_tnew_d;
   // Mult/div busy counter
   logic [CW-1:0] cnt_q, cnt_d;

   logic md_busy_w;
   logic md_stall_w;
   logic stall_w;

   // A stage can supply register x only if it really writes x and x is not $0.
   function automatic logic live(input logic v, input logic rw,
                                 input logic [AW-1:0] a3, input logic [AW-1:0] x);
      return v && rw && (a3 != '0) && (a3 == x);
   endfunction

   // Tnew counts down to zero and stays there.
   function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   // D-stage consumers (gi=0: rs, gi=1: rt): youngest writer decides select and hazard.
   for (genvar gi = 0; gi < 2; gi++) begin : g_src_d
      logic [AW-1:0] src;
      logic [TW-1:0] tuse;
      logic [2:0]    sel;
      logic          haz;
      logic          hit;
      logic [TW-1:0] ytnew;

      assign src  = (gi == 0) ? hz.rs_d : hz.rt_d;
      assign tuse = (gi == 0) ? hz.tuse_rs_d : hz.tuse_rt_d;

      // Pick the youngest live writer; older matches are shadowed by it.
      always_comb begin
         sel   = 3'b000;
         hit   = 1'b0;
         ytnew = '0;
         if (live(e_valid_q, e_regwrite_q, e_a3_q, src)) begin
            hit   = 1'b1;
            ytnew = e_tnew_q;
            sel   = (e_tnew_q == '0) ? 3'b001 : 3'b000;
         end else if (live(m_valid_q, m_regwrite_q, m_a3_q, src)) begin
            hit   = 1'b1;
            ytnew = m_tnew_q;
            sel   = (m_tnew_q == '0) ? 3'b010 : 3'b000;
         end else if (live(w_valid_q, w_regwrite_q, w_a3_q, src)) begin
            hit   = 1'b1;
            ytnew = w_tnew_q;
            sel   = (w_tnew_q == '0) ? 3'b011 : 3'b000;
         end
         haz = hit && (src != '0) && (tuse != '1) && (ytnew > tuse);
      end
   end

   // E-stage consumers (gi=0: rs, gi=1: rt) can only be fed from M or W.
   for (genvar gi = 0; gi < 2; gi++) begin : g_src_e
      logic [AW-1:0] src;
      logic [2:0]    sel;

      assign src = (gi == 0) ? e_rs_q : e_rt_q;

      // Youngest of M over W; a writer not yet ready gives no forward.
      always_comb begin
         sel = 3'b000;
         if (live(m_valid_q, m_regwrite_q, m_a3_q, src)) begin
            sel = (m_tnew_q == '0) ? 3'b001 : 3'b000;
         end else if (live(w_valid_q, w_regwrite_q, w_a3_q, src)) begin
            sel = (w_tnew_q == '0) ? 3'b011 : 3'b000;
         end
      end
   end

   assign md_busy_w  = (cnt_q != '0) || (e_valid_q && e_md_start_q);
   assign md_stall_w = (hz.md_use_d || hz.md_start_d) && md_busy_w;
   assign stall_w    = g_src_d[0].haz || g_src_d[1].haz || md_stall_w;

   assign hz.stall    = stall_w;
   assign hz.md_busy  = md_busy_w;
   assign hz.fwd_rs_d = g_src_d[0].sel;
   assign hz.fwd_rt_d = g_src_d[1].sel;
   assign hz.fwd_rs_e = g_src_e[0].sel;
   assign hz.fwd_rt_e = g_src_e[1].sel;
   // M-stage store data can only come from W.
   assign hz.fwd_rt_m = (live(w_valid_q, w_regwrite_q, w_a3_q, m_rt_q) && (w_tnew_q == '0))
                        ? 3'b001 : 3'b000;

   // Next shadow state: D->E (or an all-zero bubble), E->M->W always advance.
   always_comb begin
      e_valid_d    = 1'b0;
      e_regwrite_d = 1'b0;
      e_a3_d       = '0;
      e_tnew_d     = '0;
      e_rs_d       = '0;
      e_rt_d       = '0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
      if (!stall_w) begin
         e_valid_d    = 1'b1;
         e_regwrite_d = hz.regwrite_d;
         e_a3_d       = hz.a3_d;
         e_tnew_d     = hz.tnew_d;
         e_rs_d       = hz.rs_d;
         e_rt_d       = hz.rt_d;
         e_md_start_d = hz.md_start_d;
         e_md_div_d   = hz.md_div_d;
      end
      m_valid_d    = e_valid_q;
      m_regwrite_d = e_regwrite_q;
      m_a3_d       = e_a3_q;
      m_tnew_d     = age(e_tnew_q);
      m_rt_d       = e_rt_q;
      w_valid_d    = m_valid_q;
      w_regwrite_d = m_regwrite_q;
      w_a3_d       = m_a3_q;
      w_tnew_d     = age(m_tnew_q);
      // A mult/div leaving E reloads the counter, taking priority over the decrement.
      cnt_d = cnt_q;
      if (e_valid_q && e_md_start_q) begin
         cnt_d = e_md_div_q ? CW'(DIV_CYC) : CW'(MUL_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Shadow and counter registers; reset empties the pipeline shadow at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_q    <= 1'b0;
         e_regwrite_q <= 1'b0;
         e_a3_q       <= '0;
         e_tnew_q     <= '0;
         e_rs_q       <= '0;
         e_rt_q       <= '0;
         e_md_start_q <= 1'b0;
         e_md_div_q   <= 1'b0;
         m_valid_q    <= 1'b0;
         m_regwrite_q <= 1'b0;
         m_a3_q       <= '0;
         m_tnew_q     <= '0;
         m_rt_q       <= '0;
         w_valid_q    <= 1'b0;
         w_regwrite_q <= 1'b0;
         w_a3_q       <= '0;
         w_tnew_q     <= '0;
         cnt_q        <= '0;
      end else begin
         e_valid_q    <= e_valid_d;
         e_regwrite_q <= e_regwrite_d;
         e_a3_q       <= e_a3_d;
         e_tnew_q     <= e_tnew_d;
         e_rs_q       <= e_rs_d;
         e_rt_q       <= e_rt_d;
         e_md_start_q <= e_md_start_d;
         e_md_div_q   <= e_md_div_d;
         m_valid_q    <= m_valid_d;
         m_regwrite_q <= m_regwrite_d;
         m_a3_q       <= m_a3_d;
         m_tnew_q     <= m_tnew_d;
         m_rt_q       <= m_rt_d;
         w_valid_q    <= w_valid_d;
         w_regwrite_q <= w_regwrite_d;
         w_a3_q       <= w_a3_d;
         w_tnew_q     <= w_tnew_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations
// tagged with their cycle; a monitor compares them on the falling edge.
module tb_hazard_ctrl;

   localparam int S_STALL = 0;
   localparam int S_BUSY  = 1;
   localparam int S_RS_D  = 2;
   localparam int S_RT_D  = 3;
   localparam int S_RS_E  = 4;
   localparam int S_RT_E  = 5;
   localparam int S_RT_M  = 6;

   typedef struct {
      int         cyc;
      string      name;
      int         sig;
      logic [2:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   hazard_if #(.AW(5), .TW(2)) hz ();

   hazard_ctrl #(
      .AW(5), .TW(2), .MUL_CYC(5), .DIV_CYC(10), .CW(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   // Cycle index: cycle n is the interval after the n-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] actual(input int sig);
      case (sig)
         S_STALL: return {2'b00, hz.stall};
         S_BUSY:  return {2'b00, hz.md_busy};
         S_RS_D:  return hz.fwd_rs_d;
         S_RT_D:  return hz.fwd_rt_d;
         S_RS_E:  return hz.fwd_rs_e;
         S_RT_E:  return hz.fwd_rt_e;
         default: return hz.fwd_rt_m;
      endcase
   endfunction

   // Monitor: checks every expectation queued for the current cycle.
   initial begin
      exp_t e;
      logic [2:0] a;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
               n_err++;
               $display("FAIL %s cyc=%0d not sampled in its cycle (now %0d)", e.name, e.cyc, cyc);
            end else begin
               a = actual(e.sig);
               if (a !== e.val) begin
                  n_err++;
                  $display("FAIL %s cyc=%0d got=%b want=%b", e.name, e.cyc, a, e.val);
               end else begin
                  $display("ok   %s cyc=%0d val=%b", e.name, e.cyc, a);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int sig, input logic [2:0] val);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.sig  = sig;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic drv(input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic [4:0] a3, input logic rw, input logic [1:0] tn,
                      input logic ms, input logic md, input logic mu);
      hz.rs_d       = rs;
      hz.tuse_rs_d  = trs;
      hz.rt_d       = rt;
      hz.tuse_rt_d  = trt;
      hz.a3_d       = a3;
      hz.regwrite_d = rw;
      hz.tnew_d     = tn;
      hz.md_start_d = ms;
      hz.md_div_d   = md;
      hz.md_use_d   = mu;
   endtask

   task automatic nop();
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      nop();
      repeat (3) step();
   endtask

   // Multiply/divide followed by a dependent mflo; busy lasts cyc+1 cycles.
   task automatic md_test(input string tag, input logic is_div, input int ncyc);
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, is_div, 1'b0);
      chk({tag, "_idle_busy"}, S_BUSY, 3'd0);
      step();
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd14, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= ncyc; k++) begin
         chk({tag, "_busy"}, S_BUSY, 3'd1);
         chk({tag, "_stall"}, S_STALL, 3'd1);
         step();
      end
      chk({tag, "_done_busy"}, S_BUSY, 3'd0);
      chk({tag, "_release"}, S_STALL, 3'd0);
      step();
      drain();
   endtask

   initial begin
      // Reset with aggressive D inputs: every output must stay quiet.
      rst_n = 1'b0;
      drv(5'd8, 2'd0, 5'd8, 2'd0, 5'd8, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
      repeat (3) begin
         step();
         chk("rst_stall", S_STALL, 3'd0);
         chk("rst_busy", S_BUSY, 3'd0);
         chk("rst_rs_d", S_RS_D, 3'd0);
         chk("rst_rt_d", S_RT_D, 3'd0);
         chk("rst_rs_e", S_RS_E, 3'd0);
         chk("rst_rt_e", S_RT_E, 3'd0);
         chk("rst_rt_m", S_RT_M, 3'd0);
      end
      step();
      rst_n = 1'b1;
      nop();
      step();

      // ALU -> ALU: addu $8 (tnew 1), addu $10 <- $8 (tuse 1)
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("alu_w_stall", S_STALL, 3'd0);
      step();
      drv(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("alu_r_stall", S_STALL, 3'd0);
      chk("alu_r_fwd_d", S_RS_D, 3'd0);
      step();
      nop();
      chk("alu_fwd_rs_e", S_RS_E, 3'd1);
      chk("alu_nop_stall", S_STALL, 3'd0);
      step();
      drv(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("alu_fwd_rs_d_w", S_RS_D, 3'd3);
      chk("alu_r3_stall", S_STALL, 3'd0);
      step();
      drain();

      // lw $9 (tnew 2) -> beq rs=$9 (tuse 0): two stall cycles, then W forward
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      chk("lw_stall", S_STALL, 3'd0);
      step();
      drv(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("beq_stall1", S_STALL, 3'd1);
      chk("beq_fwd1", S_RS_D, 3'd0);
      step();
      chk("beq_stall2", S_STALL, 3'd1);
      step();
      chk("beq_go", S_STALL, 3'd0);
      chk("beq_fwd_w", S_RS_D, 3'd3);
      step();
      drain();

      // Writer with tnew 0 in E forwards to D rt at once
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
      drv(5'd0, 2'd3, 5'd12, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("e0_fwd_rt_d", S_RT_D, 3'd1);
      chk("e0_stall", S_STALL, 3'd0);
      step();
      drain();

      // Store path: addu $11 (tnew 1) then sw rt=$11 (tuse 2)
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      step();
      drv(5'd0, 2'd3, 5'd11, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("sw_stall", S_STALL, 3'd0);
      chk("sw_fwd_rt_d", S_RT_D, 3'd0);
      step();
      drv(5'd0, 2'd3, 5'd11, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("sw_fwd_rt_e", S_RT_E, 3'd1);
      chk("rd_fwd_rt_d_m", S_RT_D, 3'd2);
      chk("rd_stall", S_STALL, 3'd0);
      step();
      nop();
      chk("sw_fwd_rt_m", S_RT_M, 3'd1);
      step();
      drain();

      // Youngest match: $13 tnew 0 then $13 tnew 2; reader must wait for the younger
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      step();
      drv(5'd13, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("young_stall1", S_STALL, 3'd1);
      chk("young_fwd1", S_RS_D, 3'd0);
      step();
      chk("young_stall2", S_STALL, 3'd1);
      chk("young_fwd2", S_RS_D, 3'd0);
      step();
      chk("young_go", S_STALL, 3'd0);
      chk("young_fwd_w", S_RS_D, 3'd3);
      step();
      drain();

      // $0 writer never creates a dependency
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      step();
      drv(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("zero_stall", S_STALL, 3'd0);
      chk("zero_fwd_rs", S_RS_D, 3'd0);
      chk("zero_fwd_rt", S_RT_D, 3'd0);
      step();
      drain();

      // div -> mflo (11 busy cycles), mult -> mflo (6 busy cycles)
      md_test("div", 1'b1, 10);
      md_test("mult", 1'b0, 5);

      // Reset pulse four cycles into a divide
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      step();
      drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd14, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      chk("rdiv_busy0", S_BUSY, 3'd1);
      repeat (4) step();
      chk("rdiv_busy4", S_BUSY, 3'd1);
      chk("rdiv_stall4", S_STALL, 3'd1);
      step();
      rst_n = 1'b0;
      chk("rdiv_rst_busy", S_BUSY, 3'd0);
      chk("rdiv_rst_stall", S_STALL, 3'd0);
      step();
      rst_n = 1'b1;
      chk("rdiv_rel_busy", S_BUSY, 3'd0);
      chk("rdiv_rel_stall", S_STALL, 3'd0);
      repeat (3) begin
         step();
         chk("rdiv_after_busy", S_BUSY, 3'd0);
      end
      step();

      // Let the monitor consume what is left, bounded.
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_err += sb.size();
         n_vec += sb.size();
         $display("FAIL drain %0d expectations never checked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
